// File: rtl/array_shift_pkg.sv
// Shared types and default widths for the array shift engine.
package array_shift_pkg;

  localparam int unsigned DEF_ELEM_WIDTH = 12;
  localparam int unsigned DEF_N_AREA     = 4;
  localparam int unsigned DEF_N_ARRAYS   = 2;
  localparam int unsigned OP_WIDTH       = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    READ       = 3'd0,
    WRITE      = 3'd1,
    SHIFT_UP   = 3'd2,
    SHIFT_DOWN = 3'd3,
    RESIZE     = 3'd4,
    SIZE       = 3'd5
  } cmd_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // $clog2 that never yields a zero-width field
  function automatic int unsigned width_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_shift_engine_if.sv
// Command/response bundle between a command source (master) and the engine (slave).
interface array_shift_engine_if
  import array_shift_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = DEF_ELEM_WIDTH,
  parameter int unsigned NArea              = DEF_N_AREA,
  parameter int unsigned NArrays            = DEF_N_ARRAYS
);
  localparam int unsigned IW = $clog2(NArea + 1);
  localparam int unsigned AW = width_min1(NArrays);

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [OP_WIDTH-1:0]           cmd_op;
  logic [AW-1:0]                 cmd_array;
  logic [IW-1:0]                 cmd_index;
  logic [MemoryElementWidth-1:0] cmd_data;
  logic                          rsp_valid;
  logic [MemoryElementWidth-1:0] rsp_data;
  logic [IW-1:0]                 rsp_size;
  logic                          rsp_error;
  logic                          busy;

  modport master (
    output cmd_valid, cmd_op, cmd_array, cmd_index, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_size, rsp_error, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_array, cmd_index, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_size, rsp_error, busy
  );

endinterface

// File: rtl/array_shift_store.sv
// Heap RAM (one read, one write port) plus per-array size registers.
module array_shift_store #(
  parameter int unsigned W       = 12,
  parameter int unsigned NArea   = 4,
  parameter int unsigned NArrays = 2,
  parameter int unsigned IW      = 3,
  parameter int unsigned AW      = 1,
  parameter int unsigned HAW     = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [HAW-1:0] rd_addr,
  output logic [W-1:0]   rd_data_c,
  input  logic           we,
  input  logic [HAW-1:0] wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic [AW-1:0]  size_rd_array,
  output logic [IW-1:0]  size_rd_c,
  input  logic           size_we,
  input  logic [AW-1:0]  size_wr_array,
  input  logic [IW-1:0]  size_wr_data
);
  localparam int unsigned DEPTH = NArea * NArrays;

  logic [W-1:0]  mem     [DEPTH];
  logic [IW-1:0] sizes_q [NArrays];

  assign rd_data_c = mem[rd_addr];
  assign size_rd_c = sizes_q[size_rd_array];

  // Element storage is deliberately left uncleared by reset
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NArrays); i++) sizes_q[i] <= '0;
    end else if (size_we) begin
      sizes_q[size_wr_array] <= size_wr_data;
    end
  end

endmodule

// File: rtl/array_shift_engine.sv
// Heap-array engine: element read/write, resize, size query and multi-cycle insert/remove.
// ARRAY_SHIFT_CLEAR_EN: zero the vacated slot at the end of SHIFT_DOWN.
module array_shift_engine
  import array_shift_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = DEF_ELEM_WIDTH,
  parameter int unsigned NArea              = DEF_N_AREA,
  parameter int unsigned NArrays            = DEF_N_ARRAYS
) (
  input logic                 clock,
  input logic                 reset,
  array_shift_engine_if.slave bus
);
  localparam int unsigned W   = MemoryElementWidth;
  localparam int unsigned IW  = $clog2(NArea + 1);
  localparam int unsigned AW  = width_min1(NArrays);
  localparam int unsigned HAW = width_min1(NArea * NArrays);

  state_t        state_q;
  logic          cmd_ready_q, rsp_valid_q, rsp_error_q, busy_q, up_q;
  logic [W-1:0]  rsp_data_q, data_q, removed_q;
  logic [IW-1:0] rsp_size_q, size_q, k_q, j_q;
  logic [AW-1:0] arr_q;

  cmd_op_t        op_c;
  logic           accept_c, ok_c, shift_c, we_c, size_we_c;
  logic [HAW-1:0] rd_addr_c, wr_addr_c;
  logic [W-1:0]   rd_data_c, wr_data_c;
  logic [AW-1:0]  size_arr_c;
  logic [IW-1:0]  size_c, size_wr_data_c;

  function automatic logic [HAW-1:0] heap_addr(input logic [AW-1:0] a, input logic [IW-1:0] i);
    return HAW'(a) * HAW'(NArea) + HAW'(i);
  endfunction

  array_shift_store #(
    .W(W), .NArea(NArea), .NArrays(NArrays), .IW(IW), .AW(AW), .HAW(HAW)
  ) u_store (
    .clock         (clock),
    .reset         (reset),
    .rd_addr       (rd_addr_c),
    .rd_data_c     (rd_data_c),
    .we            (we_c),
    .wr_addr       (wr_addr_c),
    .wr_data       (wr_data_c),
    .size_rd_array (size_arr_c),
    .size_rd_c     (size_c),
    .size_we       (size_we_c),
    .size_wr_array (size_arr_c),
    .size_wr_data  (size_wr_data_c)
  );

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_size  = rsp_size_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.busy      = busy_q;

  // Store port steering: command fields while idle, shift cursor while shifting
  always_comb begin
    op_c           = cmd_op_t'(bus.cmd_op);
    accept_c       = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
    shift_c        = (op_c == SHIFT_UP) || (op_c == SHIFT_DOWN);
    size_arr_c     = bus.cmd_array;
    rd_addr_c      = heap_addr(bus.cmd_array, bus.cmd_index);
    wr_addr_c      = heap_addr(bus.cmd_array, bus.cmd_index);
    wr_data_c      = bus.cmd_data;
    we_c           = 1'b0;
    size_we_c      = 1'b0;
    size_wr_data_c = bus.cmd_index;
    case (op_c)
      READ, WRITE: ok_c = bus.cmd_index < IW'(NArea);
      SHIFT_UP:    ok_c = (size_c < IW'(NArea)) && (bus.cmd_index <= size_c);
      SHIFT_DOWN:  ok_c = bus.cmd_index < size_c;
      RESIZE:      ok_c = bus.cmd_index <= IW'(NArea);
      SIZE:        ok_c = 1'b1;
      default:     ok_c = 1'b0;
    endcase

    if (state_q == SHIFT) begin
      size_arr_c = arr_q;
      wr_addr_c  = heap_addr(arr_q, j_q);
      wr_data_c  = rd_data_c;
      we_c       = 1'b1;
      if (up_q) begin
        rd_addr_c = heap_addr(arr_q, j_q - IW'(1));
        if (j_q == k_q) begin
          wr_data_c      = data_q;
          size_we_c      = 1'b1;
          size_wr_data_c = size_q + IW'(1);
        end
      end else begin
        rd_addr_c = heap_addr(arr_q, j_q + IW'(1));
        if (j_q + IW'(1) >= size_q) begin
`ifdef ARRAY_SHIFT_CLEAR_EN
          wr_data_c = '0;
`else
          we_c = 1'b0;
`endif
          size_we_c      = 1'b1;
          size_wr_data_c = size_q - IW'(1);
        end
      end
    end else if (accept_c && ok_c) begin
      we_c           = (op_c == WRITE);
      size_we_c      = (op_c == RESIZE) || ((op_c == WRITE) && (bus.cmd_index >= size_c));
      size_wr_data_c = (op_c == WRITE) ? bus.cmd_index + IW'(1) : bus.cmd_index;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_size_q  <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
      up_q        <= 1'b0;
      data_q      <= '0;
      removed_q   <= '0;
      size_q      <= '0;
      k_q         <= '0;
      j_q         <= '0;
      arr_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept_c) begin
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          arr_q       <= bus.cmd_array;
          k_q         <= bus.cmd_index;
          data_q      <= bus.cmd_data;
          size_q      <= size_c;
          up_q        <= (op_c == SHIFT_UP);
          j_q         <= (op_c == SHIFT_UP) ? size_c : bus.cmd_index;
          removed_q   <= rd_data_c;
          if (ok_c && shift_c) begin
            state_q <= SHIFT;
          end else begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= !ok_c;
            rsp_size_q  <= size_we_c ? size_wr_data_c : size_c;
            if (ok_c && (op_c == READ)) rsp_data_q <= rd_data_c;
          end
        end
        SHIFT: begin
          if (size_we_c) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_size_q  <= size_wr_data_c;
            rsp_data_q  <= up_q ? data_q : removed_q;
          end else begin
            j_q <= up_q ? j_q - IW'(1) : j_q + IW'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_shift_engine.sv
// Directed self-checking bench for array_shift_engine (NArea=4, NArrays=2, 12-bit elements).
module tb_array_shift_engine;
  import array_shift_pkg::*;

  localparam int unsigned W  = 12;
  localparam int unsigned NA = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned IW = 3;
  localparam int unsigned AW = 1;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [W-1:0]  got_data;
  logic [IW-1:0] got_size;
  logic          got_err;
  int            got_shift, got_lat;
  int            n, rv_at, rdy_at, rv_cnt;
  logic [IW-1:0] rv_size;

  array_shift_engine_if #(.MemoryElementWidth(W), .NArea(NA), .NArrays(NR)) bus ();

  array_shift_engine #(.MemoryElementWidth(W), .NArea(NA), .NArrays(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
  endtask

  // One command: returns response fields, busy-before-response count and latency
  task automatic issue(input logic [2:0] op, input int arr, input int idx, input int data);
    int k;
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_array = AW'(arr);
    bus.cmd_index = IW'(idx);
    bus.cmd_data  = W'(data);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    got_shift = 0;
    got_lat   = 1;
    k = 0;
    while (!bus.rsp_valid && k < 50) begin
      if (bus.busy) got_shift++;
      @(negedge clock);
      got_lat++;
      k++;
    end
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    got_data = bus.rsp_data;
    got_size = bus.rsp_size;
    got_err  = bus.rsp_error;
  endtask

  task automatic read_chk(input string tag, input int arr, input int idx, input int exp);
    issue(READ, arr, idx, 0);
    check(tag, 32'(got_data), 32'(exp));
    check({tag, "_err"}, 32'(got_err), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_array = '0;
    bus.cmd_index = '0;
    bus.cmd_data  = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data",  32'(bus.rsp_data), 0);
    check("rst_rsp_size",  32'(bus.rsp_size), 0);
    check("rst_rsp_error", 32'(bus.rsp_error), 0);
    check("rst_busy",      32'(bus.busy), 0);
    reset = 1'b1;
    @(negedge clock);

    // Setup array1 = 0,1,2 with auto-extend
    issue(WRITE, 1, 0, 0);
    check("wr0_size", 32'(got_size), 1);
    check("wr0_lat",  32'(got_lat), 1);
    issue(WRITE, 1, 1, 1);
    issue(WRITE, 1, 2, 2);
    check("wr2_size", 32'(got_size), 3);
    check("wr2_err",  32'(got_err), 0);
    @(negedge clock);
    check("rsp_valid_one_cycle", 32'(bus.rsp_valid), 0);

    // Insert at 0
    issue(SHIFT_UP, 1, 0, 99);
    check("up0_size",  32'(got_size), 4);
    check("up0_busy",  32'(got_shift), 4);
    check("up0_err",   32'(got_err), 0);
    read_chk("a1_e0", 1, 0, 99);
    read_chk("a1_e1", 1, 1, 0);
    read_chk("a1_e2", 1, 2, 1);
    read_chk("a1_e3", 1, 3, 2);
    issue(SIZE, 0, 0, 0);
    check("a0_size_untouched", 32'(got_size), 0);

    // Full reject
    issue(SHIFT_UP, 1, 0, 55);
    check("full_err",  32'(got_err), 1);
    check("full_lat",  32'(got_lat), 1);
    check("full_size", 32'(got_size), 4);
    read_chk("full_e0", 1, 0, 99);
    read_chk("full_e3", 1, 3, 2);

    // Remove at 1
    issue(SHIFT_DOWN, 1, 1, 0);
    check("down1_data", 32'(got_data), 0);
    check("down1_size", 32'(got_size), 3);
    check("down1_busy", 32'(got_shift), 3);
    check("down1_err",  32'(got_err), 0);
    read_chk("dn_e0", 1, 0, 99);
    read_chk("dn_e1", 1, 1, 1);
    read_chk("dn_e2", 1, 2, 2);
`ifdef ARRAY_SHIFT_CLEAR_EN
    read_chk("dn_e3", 1, 3, 0);
`else
    read_chk("dn_e3", 1, 3, 2);
`endif

    // Append and bounds on array0
    issue(SHIFT_UP, 0, 0, 7);
    check("app_size", 32'(got_size), 1);
    check("app_busy", 32'(got_shift), 1);
    read_chk("app_e0", 0, 0, 7);
    issue(SHIFT_UP, 0, 3, 5);
    check("up_oob_err",  32'(got_err), 1);
    check("up_oob_size", 32'(got_size), 1);
    issue(RESIZE, 0, 0, 0);
    check("resize0_size", 32'(got_size), 0);
    check("resize0_err",  32'(got_err), 0);
    issue(SHIFT_DOWN, 0, 0, 0);
    check("down_empty_err",  32'(got_err), 1);
    check("down_empty_size", 32'(got_size), 0);
    issue(RESIZE, 0, 5, 0);
    check("resize_oob_err", 32'(got_err), 1);
    issue(3'd6, 0, 0, 0);
    check("reserved_err", 32'(got_err), 1);
    issue(WRITE, 0, 4, 9);
    check("wr_oob_err",  32'(got_err), 1);
    check("wr_oob_size", 32'(got_size), 0);

    // Back-to-back: WRITE held valid during a shift
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = SHIFT_UP;
    bus.cmd_array = AW'(1);
    bus.cmd_index = IW'(0);
    bus.cmd_data  = W'(50);
    @(negedge clock);
    bus.cmd_op    = WRITE;
    bus.cmd_array = AW'(0);
    bus.cmd_index = IW'(0);
    bus.cmd_data  = W'(33);
    n = 1; rv_at = -1; rdy_at = -1; rv_cnt = 0; rv_size = '0;
    while (rdy_at < 0 && n < 40) begin
      if (bus.cmd_ready) rdy_at = n;
      else begin
        if (bus.rsp_valid) begin
          rv_cnt++;
          rv_at = n;
          rv_size = bus.rsp_size;
        end
        @(negedge clock);
        n++;
      end
    end
    check("b2b_rsp_at",   32'(rv_at), 5);
    check("b2b_ready_at", 32'(rdy_at), 6);
    check("b2b_rsp_cnt",  32'(rv_cnt), 1);
    check("b2b_up_size",  32'(rv_size), 4);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    check("b2b_wr_valid", 32'(bus.rsp_valid), 1);
    check("b2b_wr_size",  32'(bus.rsp_size), 1);
    check("b2b_wr_ready", 32'(bus.cmd_ready), 0);
    rv_cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.rsp_valid) rv_cnt++;
    end
    check("b2b_single_accept", 32'(rv_cnt), 0);
    read_chk("b2b_a1_e0", 1, 0, 50);
    read_chk("b2b_a1_e1", 1, 1, 99);
    read_chk("b2b_a1_e3", 1, 3, 2);
    read_chk("b2b_a0_e0", 0, 0, 33);

    // Reset during the 2nd SHIFT cycle of an insert
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = SHIFT_UP;
    bus.cmd_array = AW'(0);
    bus.cmd_index = IW'(0);
    bus.cmd_data  = W'(8);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    check("mid_busy1", 32'(bus.busy), 1);
    @(negedge clock);
    check("mid_busy2", 32'(bus.busy), 1);
    check("mid_valid2", 32'(bus.rsp_valid), 0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.cmd_ready), 1);
    check("mid_rst_busy",  32'(bus.busy), 0);
    check("mid_rst_valid", 32'(bus.rsp_valid), 0);
    check("mid_rst_size",  32'(bus.rsp_size), 0);
    @(negedge clock);
    reset = 1'b1;
    rv_cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.rsp_valid) rv_cnt++;
    end
    check("mid_no_rsp", 32'(rv_cnt), 0);
    issue(SIZE, 0, 0, 0);
    check("mid_size_a0", 32'(got_size), 0);
    issue(SIZE, 1, 0, 0);
    check("mid_size_a1", 32'(got_size), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_shift_engine.md
Name: array_shift_engine

Overview:
- Parametrised heap-array engine holding NArrays arrays of NArea elements each, plus a per-array size register.
- Serves element read/write, resize and size-query commands.
- Multi-cycle shift-up (insert at any index) and shift-down (remove at any index); generalises the fixed insert-at-0 shiftUp.
- Sits beside the instruction sequencer in fpga test harnesses; one command in flight at a time, valid/ready handshake.

Parameters:
- MemoryElementWidth, 12, element width in bits.
- NArea, 4, elements per array (array capacity).
- NArrays, 2, number of arrays; heap depth is NArea*NArrays.
- IW, $clog2(NArea+1), index/size width.
- AW, $clog2(NArrays) (minimum 1), array-number width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept; high only in IDLE.
- cmd_op  in  3  0 READ, 1 WRITE, 2 SHIFT_UP, 3 SHIFT_DOWN, 4 RESIZE, 5 SIZE; 6-7 reserved.
- cmd_array  in  AW  target array.
- cmd_index  in  IW  element index, or new size for RESIZE.
- cmd_data  in  MemoryElementWidth  write/insert value.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  MemoryElementWidth  read value or removed value.
- rsp_size  out  IW  array size after the command.
- rsp_error  out  1  command rejected, with rsp_valid.
- busy  out  1  high in SHIFT and DONE.

Behaviour:
- Reset (async, reset low): state IDLE; cmd_ready=1; rsp_valid=0, rsp_data=0, rsp_size=0, rsp_error=0, busy=0; all sizes 0. Element storage is not cleared.
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready. All command fields are captured at that edge.
- States:
  - IDLE: on accept, go to SHIFT for SHIFT_UP/SHIFT_DOWN; otherwise go to DONE.
  - SHIFT: move one element per cycle.
  - DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency for READ, WRITE, RESIZE and SIZE: rsp_valid in the cycle after acceptance.
- WRITE: valid when idx<NArea.
  - Stores data.
  - If idx+1 > size, size becomes idx+1 (auto-extend).
- READ: valid when idx<NArea; reads beyond size are legal and return raw storage.
- RESIZE: valid when idx<=NArea; sets size=idx and leaves data untouched.
- SIZE: returns size in rsp_size; never errors.
- SHIFT_UP(k, v): valid when size<NArea and k<=size.
  - Copies elem[j]=elem[j-1] for j=size down to k+1, one per cycle.
  - Then writes elem[k]=v and increments size.
  - Busy cycles = (size-k)+1, then DONE.
  - k==size is an append: 1 SHIFT cycle.
- SHIFT_DOWN(k): valid when k<size.
  - Captures elem[k] into rsp_data.
  - Copies elem[j]=elem[j+1] for j=k to size-2, then decrements size.
  - Busy cycles = max(size-1-k,0)+1.
- Error cases:
  - Any invalid case (full, index out of range, empty shift-down, reserved op) goes IDLE to DONE.
  - rsp_error=1, storage and sizes unchanged, rsp_size = current size.
- Arithmetic: heap address = array*NArea + index, computed at width $clog2(NArea*NArrays). Size comparisons are unsigned at IW bits.
- Reset mid-shift: the operation aborts, sizes clear, no rsp_valid. Partially shifted data may remain in storage.
- Outputs rsp_data, rsp_size and rsp_error hold their last values until the next DONE.

Optional Feature:
- Macro: ARRAY_SHIFT_CLEAR_EN.
- Defined: SHIFT_DOWN writes 0 to the vacated slot elem[size-1] in its final SHIFT cycle. Busy cycle count is unchanged.
- Undefined: the vacated slot retains its stale value (the duplicated former last element).

Decomposition:
- Package array_shift_pkg holds:
  - typedef enum cmd_op_t (READ, WRITE, SHIFT_UP, SHIFT_DOWN, RESIZE, SIZE).
  - typedef enum state_t (IDLE, SHIFT, DONE).
  - Default width constants.
- One natural sub-module: array_shift_store. It contains the heap RAM plus size registers, with one read port and one write port per cycle. The engine FSM drives it.

Test Plan:
- Setup and insert at 0: WRITE array1 idx0..2 = 0,1,2, then SHIFT_UP array1 k=0 v=99.
  - rsp_size=4 after 4 busy cycles.
  - READ idx0..3 returns 99,0,1,2.
  - array0 is untouched.
- Full reject: SHIFT_UP array1 again when size=4. Response: rsp_error=1 one cycle after accept, size stays 4, data unchanged.
- Remove at 1: SHIFT_DOWN array1 k=1 starting from 99,0,1,2.
  - rsp_data=0, rsp_size=3, 3 busy cycles.
  - READ idx0..2 returns 99,1,2.
  - READ idx3 returns 0 with ARRAY_SHIFT_CLEAR_EN, 2 without.
- Append and bounds: SHIFT_UP array0 k=0 v=7 on an empty array gives size 1 and elem0=7. Then SHIFT_UP k=3 gives rsp_error=1. SHIFT_DOWN on an empty array gives rsp_error=1.
- Reset mid-shift: assert reset low during the 2nd SHIFT cycle of the insert. Required: immediate IDLE, cmd_ready=1, no rsp_valid, SIZE returns 0 for both arrays.
- Back-to-back handshake: hold cmd_valid high with a queued WRITE during a shift. Required: cmd_ready=0 until IDLE; the WRITE is accepted exactly once, in the cycle after rsp_valid.
